aes_trace_sequencer: RTL and testbench

Initiator-side driver for the static-key AES core's load/busy handshake in the no-I/O power-analysis build. Internally generates plaintexts with a 128-bit LFSR and issues one encryption per trace. Frames each encryption with a scope trigger and captures the ciphertext. Sits between the board-level run control and the AES core, replacing any external data path.

---
 rtl/aes_trace_sequencer_if.sv | 25 ++
 rtl/aes_trace_sequencer.sv | 179 +++++++++++++++++
 tb/tb_aes_trace_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_trace_sequencer_if.sv
// Load/busy handshake between the trace sequencer (master) and the AES core (slave).
// Signal names keep the sequencer-side direction suffixes used on the board netlist.
interface aes_trace_sequencer_if;
  logic         aes_load_o;
  logic [127:0] aes_data_o;
  logic         aes_dec_o;
  logic         aes_busy_i;
  logic [127:0] aes_data_i;

  modport master (
    output aes_load_o,
    output aes_data_o,
    output aes_dec_o,
    input  aes_busy_i,
    input  aes_data_i
  );

  modport slave (
    input  aes_load_o,
    input  aes_data_o,
    input  aes_dec_o,
    output aes_busy_i,
    output aes_data_i
  );
endinterface

// File: rtl/aes_trace_sequencer.sv
// Power-analysis trace sequencer: LFSR plaintexts, one framed encryption per trace.
// Define AES_TRACE_ROUNDTRIP_EN to add a decrypt leg that checks each ciphertext.
module aes_trace_sequencer #(
  parameter logic [127:0] SEED       = 128'h00112233445566778899aabbccddeeff,
  parameter int unsigned  GAP_CYCLES = 16,
  parameter int unsigned  TIMEOUT    = 100,
  parameter int unsigned  NUM_TRACES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  aes_trace_sequencer_if.master aes,
  output logic                  trigger_o,
  output logic [127:0]          ct_o,
  output logic                  done_o,
  output logic [15:0]           count_o,
  output logic                  error_o,
  output logic                  mismatch_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [15:0]   GMAX = 16'(GAP_CYCLES - 1);
  localparam logic [15:0]   NTR  = 16'(NUM_TRACES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ENC,
`ifdef AES_TRACE_ROUNDTRIP_EN
    DLOAD,
    WAIT_DEC,
`endif
    GAP,
    HALT
  } state_t;

  state_t          st;
  logic [127:0]    pt;
  logic [TW-1:0]   tcnt;
  logic [15:0]     gcnt;
  logic            first;
  logic            load_q;
  logic [127:0]    data_q;
  logic            wait_fail;
  logic            wait_done;

  function automatic logic [127:0] lfsr_step(input logic [127:0] v);
    return {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The core must raise busy on the cycle after the load; after that, busy may
  // stay high for at most TIMEOUT cycles in total.
  assign wait_fail = (first && !aes.aes_busy_i) || (aes.aes_busy_i && tcnt == TMAX);
  assign wait_done = !first && !aes.aes_busy_i;

  assign aes.aes_load_o = load_q;
  assign aes.aes_data_o = data_q;

`ifdef AES_TRACE_ROUNDTRIP_EN
  logic dec_q;
  logic mis_q;
  assign aes.aes_dec_o = dec_q;
  assign mismatch_o    = mis_q;
`else
  assign aes.aes_dec_o = 1'b0;
  assign mismatch_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      pt        <= SEED;
      tcnt      <= '0;
      gcnt      <= '0;
      first     <= 1'b0;
      load_q    <= 1'b0;
      data_q    <= SEED;
      trigger_o <= 1'b0;
      ct_o      <= '0;
      done_o    <= 1'b0;
      count_o   <= '0;
      error_o   <= 1'b0;
`ifdef AES_TRACE_ROUNDTRIP_EN
      dec_q     <= 1'b0;
      mis_q     <= 1'b0;
`endif
    end else begin
      load_q <= 1'b0;
      done_o <= 1'b0;
      case (st)
        IDLE: begin
          if (run_i && !error_o) begin
            if (NUM_TRACES != 0 && count_o == NTR) begin
              st <= HALT;
            end else begin
              st        <= LOAD;
              load_q    <= 1'b1;
              data_q    <= pt;
              trigger_o <= 1'b1;
            end
          end
        end

        LOAD: begin
          st    <= WAIT_ENC;
          tcnt  <= '0;
          first <= 1'b1;
        end

        WAIT_ENC: begin
          first <= 1'b0;
          if (wait_fail) begin
            error_o   <= 1'b1;
            trigger_o <= 1'b0;
            st        <= IDLE;
          end else if (wait_done) begin
            ct_o      <= aes.aes_data_i;
            trigger_o <= 1'b0;
`ifdef AES_TRACE_ROUNDTRIP_EN
            st     <= DLOAD;
            load_q <= 1'b1;
            data_q <= aes.aes_data_i;
            dec_q  <= 1'b1;
`else
            st      <= GAP;
            gcnt    <= '0;
            done_o  <= 1'b1;
            count_o <= sat_inc(count_o);
            pt      <= lfsr_step(pt);
`endif
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

`ifdef AES_TRACE_ROUNDTRIP_EN
        DLOAD: begin
          st    <= WAIT_DEC;
          dec_q <= 1'b0;
          tcnt  <= '0;
          first <= 1'b1;
        end

        WAIT_DEC: begin
          first <= 1'b0;
          if (wait_fail) begin
            error_o <= 1'b1;
            st      <= IDLE;
          end else if (wait_done) begin
            if (aes.aes_data_i != pt) mis_q <= 1'b1;
            st      <= GAP;
            gcnt    <= '0;
            done_o  <= 1'b1;
            count_o <= sat_inc(count_o);
            pt      <= lfsr_step(pt);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
`endif

        GAP: begin
          if (gcnt == GMAX) st <= IDLE;
          else              gcnt <= gcnt + 16'd1;
        end

        HALT: st <= HALT;

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: stub AES core, trace-timeline model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_aes_trace_sequencer;

  localparam logic [127:0] SEED    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_REF  = 128'h62f679be2bf0d931641e039ca3401bb2;
  localparam logic [127:0] PT2_REF = 128'h0022446688aaccef1133557799bbddff;
  localparam logic [127:0] MASK    = SEED ^ CT_REF;
  localparam int GAP = 4;
  localparam int TMO = 12;
  localparam int NTR = 3;
  localparam int LAT = 5;
  localparam int E   = LAT + 2;
`ifdef AES_TRACE_ROUNDTRIP_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif
  localparam int T = RT ? 2 * E : E;

  localparam int M_NORMAL = 0;
  localparam int M_STUCK  = 1;
  localparam int M_NEVER  = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_TRACE = 1;
  localparam int PH_HALT  = 2;
  localparam int PH_DEAD  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic         trigger;
  logic [127:0] ct;
  logic         done;
  logic [15:0]  count;
  logic         error;
  logic         mismatch;
  int           mode = M_NORMAL;

  int n_cmp = 0;
  int n_bad = 0;

  aes_trace_sequencer_if bus();

  aes_trace_sequencer #(
    .SEED(SEED), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .NUM_TRACES(NTR)
  ) dut (
    .clk(clk), .rst(rst), .run_i(run), .aes(bus),
    .trigger_o(trigger), .ct_o(ct), .done_o(done), .count_o(count),
    .error_o(error), .mismatch_o(mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_fn(input logic [127:0] v);
    return v ^ MASK;
  endfunction

  function automatic logic [127:0] lfsr(input logic [127:0] v);
    return {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Stub core: busy high for LAT cycles after a load; XOR with MASK is its own inverse.
  logic [127:0] core_res;
  int           core_cnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.aes_busy_i <= 1'b0;
      bus.aes_data_i <= '0;
      core_cnt       <= 0;
    end else if (bus.aes_load_o && mode != M_NEVER) begin
      bus.aes_busy_i <= 1'b1;
      core_cnt       <= LAT - 1;
      core_res       <= core_fn(bus.aes_data_o);
    end else if (bus.aes_busy_i && mode == M_NORMAL) begin
      if (core_cnt == 0) begin
        bus.aes_busy_i <= 1'b0;
        bus.aes_data_i <= core_res;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Timeline model: each trace is laid out as offsets k from its load cycle.
  bit           m_on = 1'b0;
  int           ph = PH_IDLE;
  int           cyc = 0;
  int           ls = 0;
  int           k;
  logic [127:0] m_pt, m_ct, m_data;
  logic [15:0]  m_cnt;
  logic         m_err;
  logic         e_load, e_dec, e_trig, e_done;

  task automatic model_reset();
    ph     = PH_IDLE;
    m_pt   = SEED;
    m_data = SEED;
    m_ct   = '0;
    m_cnt  = '0;
    m_err  = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (m_on) begin
      e_load = 1'b0;
      e_dec  = 1'b0;
      e_trig = 1'b0;
      e_done = 1'b0;
      if (ph == PH_TRACE) begin
        k = cyc - ls;
        if (k == 0) begin
          e_load = 1'b1;
          m_data = m_pt;
        end
        if (mode == M_NEVER) begin
          e_trig = (k <= 1);
          if (k == 2) begin m_err = 1'b1; ph = PH_DEAD; end
        end else if (mode == M_STUCK) begin
          e_trig = (k <= TMO);
          if (k == TMO + 1) begin m_err = 1'b1; ph = PH_DEAD; end
        end else begin
          e_trig = (k < E);
          if (k == E) m_ct = core_fn(m_pt);
          if (RT && k == E) begin
            e_load = 1'b1;
            e_dec  = 1'b1;
            m_data = m_ct;
          end
          if (k == T) begin
            e_done = 1'b1;
            m_cnt  = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            m_pt   = lfsr(m_pt);
          end
          if (k == T + GAP) ph = PH_IDLE;
        end
      end
      chk("load",     128'(bus.aes_load_o), 128'(e_load));
      chk("dec",      128'(bus.aes_dec_o),  128'(e_dec));
      chk("data_o",   bus.aes_data_o,       m_data);
      chk("trigger",  128'(trigger),        128'(e_trig));
      chk("done",     128'(done),           128'(e_done));
      chk("count",    128'(count),          128'(m_cnt));
      chk("ct",       ct,                   m_ct);
      chk("error",    128'(error),          128'(m_err));
      chk("mismatch", 128'(mismatch),       128'(1'b0));
      if (rst) begin
        model_reset();
      end else if (ph == PH_IDLE && !m_err && run) begin
        if (m_cnt == 16'(NTR)) begin
          ph = PH_HALT;
        end else begin
          ph = PH_TRACE;
          ls = cyc + 1;
        end
      end
    end else if (rst) begin
      m_on = 1'b1;
      model_reset();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit ev(input int which);
    case (which)
      0:       return bus.aes_load_o && !bus.aes_dec_o;
      1:       return bus.aes_load_o && bus.aes_dec_o;
      2:       return done;
      default: return error;
    endcase
  endfunction

  task automatic wait_ev(input int which, input int maxc, input string nm, output int n);
    n = 0;
    while (!ev(which) && n < maxc) begin
      tick(1);
      n++;
    end
    if (!ev(which)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event absent after %0d cycles", nm, maxc);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_load"},  128'(bus.aes_load_o), 128'(1'b0));
    chk({nm, "_dec"},   128'(bus.aes_dec_o),  128'(1'b0));
    chk({nm, "_trig"},  128'(trigger),        128'(1'b0));
    chk({nm, "_done"},  128'(done),           128'(1'b0));
    chk({nm, "_err"},   128'(error),          128'(1'b0));
    chk({nm, "_mis"},   128'(mismatch),       128'(1'b0));
    chk({nm, "_count"}, 128'(count),          128'(16'd0));
    chk({nm, "_ct"},    ct,                   128'd0);
    chk({nm, "_data"},  bus.aes_data_o,       SEED);
  endtask

  task automatic count_loads(input int cycles, output int loads);
    loads = 0;
    for (int i = 0; i < cycles; i++) begin
      tick(1);
      if (bus.aes_load_o) loads++;
    end
  endtask

  initial begin
    int n, tot, loads;

    // Reset and first trace
    tick(3);
    rst = 1'b0;
    chk_reset_vals("reset");
    run = 1'b1;
    wait_ev(0, 10, "first_load", n);
    chk("first_load_lat", 128'(n), 128'(1));
    chk("first_pt", bus.aes_data_o, SEED);
    chk("trig_at_load", 128'(trigger), 128'(1'b1));
    n = 0;
    while (trigger && n < 50) begin
      tick(1);
      n++;
    end
    chk("trig_len", 128'(n), 128'(7));
    tot = n;
`ifdef AES_TRACE_ROUNDTRIP_EN
    wait_ev(1, 5, "dload", n);
    chk("dload_data", bus.aes_data_o, CT_REF);
    chk("dload_dec", 128'(bus.aes_dec_o), 128'(1'b1));
    chk("dload_trig", 128'(trigger), 128'(1'b0));
    tot += n;
`endif
    wait_ev(2, 40, "done1", n);
    tot += n;
    chk("ct1", ct, CT_REF);
    chk("count1", 128'(count), 128'(16'd1));
    chk("mis1", 128'(mismatch), 128'(1'b0));
    wait_ev(0, 40, "load2", n);
    tot += n;
    chk("period", 128'(tot), RT ? 128'(19) : 128'(12));
    chk("pt2", bus.aes_data_o, PT2_REF);

    // Trace limit
    wait_ev(2, 60, "done2", n);
    chk("count2", 128'(count), 128'(16'd2));
    tick(1);
    wait_ev(2, 60, "done3", n);
    chk("count3", 128'(count), 128'(16'd3));
    count_loads(40, loads);
    chk("halt_loads", 128'(loads), 128'(0));
    chk("halt_count", 128'(count), 128'(16'd3));

    // Reset in the middle of the encryption wait
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    wait_ev(0, 10, "load_rst", n);
    tick(2);
    rst = 1'b1;
    run = 1'b0;
    tick(1);
    chk_reset_vals("midrst");
    rst = 1'b0;

    // run dropped mid-trace: trace completes, then no more loads
    run = 1'b1;
    wait_ev(0, 10, "load_drop", n);
    tick(1);
    run = 1'b0;
    wait_ev(2, 60, "done_drop", n);
    chk("count_drop", 128'(count), 128'(16'd1));
    count_loads(40, loads);
    chk("drop_loads", 128'(loads), 128'(0));
    run = 1'b1;
    wait_ev(0, 10, "load_resume", n);
    chk("resume_pt", bus.aes_data_o, PT2_REF);

    // Busy stuck high
    rst  = 1'b1;
    mode = M_STUCK;
    tick(1);
    rst = 1'b0;
    wait_ev(0, 10, "load_tmo", n);
    wait_ev(3, 100, "err_tmo", n);
    chk("tmo_lat", 128'(n), 128'(TMO + 1));
    chk("tmo_trig", 128'(trigger), 128'(1'b0));
    count_loads(40, loads);
    chk("tmo_loads", 128'(loads), 128'(0));
    chk("tmo_sticky", 128'(error), 128'(1'b1));

    // Busy never rises
    rst  = 1'b1;
    mode = M_NEVER;
    tick(1);
    rst = 1'b0;
    wait_ev(0, 10, "load_never", n);
    wait_ev(3, 20, "err_never", n);
    chk("never_lat", 128'(n), 128'(2));
    count_loads(20, loads);
    chk("never_loads", 128'(loads), 128'(0));

    rst = 1'b1;
    run = 1'b0;
    mode = M_NORMAL;
    tick(1);
    chk("err_cleared", 128'(error), 128'(1'b0));
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
